tt_um_izaiahthigpen_prbs31_chk: RTL and testbench

TT_UM_IZAIAHTHIGPEN_PRBS31_CHK -- requirements
Module: tt_um_izaiahthigpen_prbs31_chk

---
 rtl/prbs31_chk_pkg.sv | 12 +
 rtl/prbs31_predictor.sv | 27 ++
 rtl/tt_um_izaiahthigpen_prbs31_chk.sv | 136 +++++++++++++
 tb/tb_tt_um_izaiahthigpen_prbs31_chk.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs31_chk_pkg.sv
// prbs31_chk_pkg: shared state encoding and PRBS31 constants for the checker
package prbs31_chk_pkg;
    typedef enum logic [1:0] {
        SEED   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;
    localparam int S_W    = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;
    localparam int ERR_W  = 8;
endpackage

// File: rtl/prbs31_predictor.sv
// prbs31_predictor: reference register s, shift-source mux and x^31+x^28+1 prediction; zero_o only with PRBS31_CHK_ZERO_DET_EN
module prbs31_predictor
    import prbs31_chk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic shift_i,
    input  logic use_pred_i,
    input  logic rx_i,
    output logic pred_o
`ifdef PRBS31_CHK_ZERO_DET_EN
    ,
    output logic zero_o
`endif
);
    logic [S_W-1:0] s_q, s_d;
    assign pred_o = s_q[TAP_HI] ^ s_q[TAP_LO];
    assign s_d    = shift_i ? {s_q[S_W-2:0], use_pred_i ? pred_o : rx_i} : s_q;
`ifdef PRBS31_CHK_ZERO_DET_EN
    assign zero_o = ~|{s_q[S_W-2:0], rx_i};
`endif
    // reference register: shifts one bit per accepted, non-resync cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else        s_q <= s_d;
    end
endmodule

// File: rtl/tt_um_izaiahthigpen_prbs31_chk.sv
// tt_um_izaiahthigpen_prbs31_chk: PRBS31 lock/error checker; PRBS31_CHK_ZERO_DET_EN rejects all-zero seeds
module tt_um_izaiahthigpen_prbs31_chk
    import prbs31_chk_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int LOSS_WIN    = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int TW = $clog2(LOSS_THRESH + 1);
    state_t           state_q, state_d;
    logic [4:0]       seed_q, seed_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [TW-1:0]    werr_q, werr_d, werr_inc;
    logic [ERR_W-1:0] err_q, err_d;
    logic             zf_q, zf_d, pulse_q, lock_q;
    logic             acc, rsy, clr, shift, pred, mism, lk_err, zero_s, unused_ok;
    assign acc       = ena & ui_in[1];
    assign clr       = ena & ui_in[2];
    assign rsy       = ena & ui_in[3];
    assign shift     = acc & ~rsy;
    assign mism      = shift & (ui_in[0] != pred);
    assign lk_err    = mism & (state_q == LOCKED);
    assign werr_inc  = werr_q + {{(TW-1){1'b0}}, lk_err};
    assign unused_ok = &{1'b0, uio_in, ui_in[7:4]};
    prbs31_predictor u_pred (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_i    (shift),
        .use_pred_i (state_q == LOCKED),
        .rx_i       (ui_in[0]),
        .pred_o     (pred)
`ifdef PRBS31_CHK_ZERO_DET_EN
        ,
        .zero_o     (zero_s)
`endif
    );
`ifndef PRBS31_CHK_ZERO_DET_EN
    assign zero_s = 1'b0;
`endif
    // next-state: seeding, verification and windowed loss-of-lock; resync overrides all
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        zf_d    = zf_q;
        if (rsy) begin
            state_d = SEED;
            seed_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
        end else if (acc) begin
            case (state_q)
                SEED: begin
                    seed_d = seed_q + 5'd1;
                    if (seed_q == 5'd30) begin
                        seed_d  = '0;
                        match_d = '0;
`ifdef PRBS31_CHK_ZERO_DET_EN
                        zf_d    = zero_s;
                        state_d = zero_s ? SEED : VERIFY;
`else
                        state_d = VERIFY;
`endif
                    end
                end
                VERIFY: begin
                    match_d = match_q + 1'b1;
                    if (mism) begin
                        state_d = SEED;
                        seed_d  = '0;
                    end else if (match_q == MW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                LOCKED: begin
                    win_d  = (win_q == WW'(LOSS_WIN - 1)) ? '0 : win_q + 1'b1;
                    werr_d = (win_q == WW'(LOSS_WIN - 1)) ? '0 : werr_inc;
                    if (werr_inc == TW'(LOSS_THRESH)) begin
                        state_d = SEED;
                        seed_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end
    // error counter saturates at all-ones; clear takes priority over a same-cycle error
    assign err_d = clr ? '0 : (lk_err && !(&err_q)) ? err_q + 1'b1 : err_q;
    // state and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
            seed_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err_q   <= '0;
            zf_q    <= 1'b0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
            zf_q    <= zf_d;
            pulse_q <= lk_err;
            lock_q  <= (state_d == LOCKED);
        end
    end
    assign uo_out  = err_q;
    assign uio_out = {3'b000, zf_q, state_q, pulse_q, lock_q};
    assign uio_oe  = 8'h1F;
endmodule

// File: tb/tb_tt_um_izaiahthigpen_prbs31_chk.sv
// tb_tt_um_izaiahthigpen_prbs31_chk: table vectors, directed sequences and random stimulus against a history-queue model
module tb_tt_um_izaiahthigpen_prbs31_chk;
    localparam int LOCK_CNT = 64, LOSS_WIN = 64, LOSS_THRESH = 8;
    logic clk = 0, rst_n = 0, ena = 0;
    logic [7:0] ui_in = 0, uio_in = 0, uo_out, uio_out, uio_oe;
    int n_chk = 0, n_pass = 0;
    logic [30:0] tx;
    bit force_zero = 0;
    bit mh[$];
    int ms, mseed, mmatch, mwin, mwerr, merr;
    bit mpulse, mlock, mzf;
    typedef struct {
        bit e, v, f, c, r;
        logic [7:0] uo, uio;
    } vec_t;
    vec_t tbl[8];

    tt_um_izaiahthigpen_prbs31_chk dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    endtask

    task automatic m_reset();
        mh = {};
        repeat (31) mh.push_back(1'b0);
        ms = 0; mseed = 0; mmatch = 0; mwin = 0; mwerr = 0; merr = 0;
        mpulse = 0; mlock = 0; mzf = 0;
    endtask

    task automatic m_step(input bit e, v, d, c, r);
        bit p, er;
        int ones;
        er = 0;
        if (!e) begin
            mpulse = 0;
            return;
        end
        p = mh[0] ^ mh[3];
        if (r) begin
            ms = 0; mseed = 0; mmatch = 0; mwin = 0; mwerr = 0;
        end else if (v) begin
            mh.push_back(ms == 2 ? p : d);
            void'(mh.pop_front());
            er = (ms == 2) && (d != p);
            case (ms)
                0: begin
                    mseed++;
                    if (mseed == 31) begin
                        mseed = 0; mmatch = 0;
                        ones = 0;
                        foreach (mh[i]) ones += int'(mh[i]);
`ifdef PRBS31_CHK_ZERO_DET_EN
                        mzf = (ones == 0);
                        ms = mzf ? 0 : 1;
`else
                        ms = 1;
`endif
                    end
                end
                1: begin
                    if (d != p) begin
                        ms = 0; mseed = 0;
                    end else begin
                        mmatch++;
                        if (mmatch == LOCK_CNT) begin
                            ms = 2; mwin = 0; mwerr = 0;
                        end
                    end
                end
                default: begin
                    mwerr += int'(er);
                    if (mwerr == LOSS_THRESH) begin
                        ms = 0; mseed = 0; mmatch = 0; mwin = 0; mwerr = 0;
                    end else begin
                        mwin++;
                        if (mwin == LOSS_WIN) begin
                            mwin = 0; mwerr = 0;
                        end
                    end
                end
            endcase
        end
        merr = c ? 0 : (er && merr < 255) ? merr + 1 : merr;
        mpulse = er;
        mlock = (ms == 2);
    endtask

    task automatic cyc(input bit e, v, f, c, r);
        bit d;
        d = force_zero ? 1'b0 : ((tx[30] ^ tx[27]) ^ f);
        if (e && v && !r) tx = {tx[29:0], tx[30] ^ tx[27]};
        ena = e;
        ui_in = {4'($urandom), r, c, v, d};
        uio_in = 8'($urandom);
        @(posedge clk);
        m_step(e, v, d, c, r);
        @(negedge clk);
        chk("uo_out", uo_out, 8'(merr));
        chk("uio_out", uio_out, {3'b000, mzf, 2'(ms), mpulse, mlock});
        chk("uio_oe", uio_oe, 8'h1F);
    endtask

    task automatic send(input int n, input bit f);
        for (int i = 0; i < n; i++) cyc(1, 1, f, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h1F);
        m_reset();
        tx = 31'h7FFF_FFFF;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic lock_up(input string tag);
        send(94, 0);
        chk({tag, "_lock94"}, {7'b0, uio_out[0]}, 8'h00);
        send(1, 0);
        chk({tag, "_lock95"}, {7'b0, uio_out[0]}, 8'h01);
        chk({tag, "_state95"}, {6'b0, uio_out[3:2]}, 8'h02);
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 0, 0, 8'd0, 8'h09};
        tbl[1] = '{1, 1, 1, 0, 0, 8'd1, 8'h0B};
        tbl[2] = '{1, 1, 0, 0, 0, 8'd1, 8'h09};
        tbl[3] = '{1, 0, 1, 0, 0, 8'd1, 8'h09};
        tbl[4] = '{0, 1, 1, 1, 0, 8'd1, 8'h09};
        tbl[5] = '{1, 1, 1, 1, 0, 8'd0, 8'h0B};
        tbl[6] = '{1, 1, 0, 0, 0, 8'd0, 8'h09};
        tbl[7] = '{1, 0, 0, 0, 1, 8'd0, 8'h00};

        do_reset();
        lock_up("prbs");
        chk("prbs_uo95", uo_out, 8'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].e, tbl[i].v, tbl[i].f, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d_uo", i), uo_out, tbl[i].uo);
            chk($sformatf("tbl%0d_uio", i), uio_out, tbl[i].uio);
        end

        lock_up("relock");
        send(10, 0);
        send(8, 1);
        chk("win_uo", uo_out, 8'd8);
        chk("win_state", {6'b0, uio_out[3:2]}, 8'h00);
        chk("win_lock", {7'b0, uio_out[0]}, 8'h00);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        lock_up("sat");
        for (int i = 0; i < 300; i++) begin
            send(1, 1);
            send(9, 0);
        end
        chk("sat_uo", uo_out, 8'd255);
        chk("sat_lock", {7'b0, uio_out[0]}, 8'h01);
        cyc(1, 1, 1, 1, 0);
        chk("clr_err_uo", uo_out, 8'd0);

        do_reset();
        force_zero = 1;
        send(200, 0);
        force_zero = 0;
`ifdef PRBS31_CHK_ZERO_DET_EN
        chk("zero_lock", {7'b0, uio_out[0]}, 8'h00);
        chk("zero_flag", {7'b0, uio_out[4]}, 8'h01);
`else
        chk("zero_lock", {7'b0, uio_out[0]}, 8'h01);
        chk("zero_flag", {7'b0, uio_out[4]}, 8'h00);
`endif

        do_reset();
        lock_up("ena");
        send(5, 1);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1, 1);
        chk("ena_uo", uo_out, 8'd5);
        chk("ena_lock", {7'b0, uio_out[0]}, 8'h01);
        send(50, 0);
        chk("ena_resume_uo", uo_out, 8'd5);
        chk("ena_resume_lock", {7'b0, uio_out[0]}, 8'h01);

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0,
                $urandom_range(0, 499) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
